// File: rtl/cpu_core_pkg.sv
// Shared ISA definitions for the 16-bit load/store core: opcodes, FSM states,
// instruction field positions and the sign-extension helper.
package cpu_pkg;

   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 16;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RS_MSB  = 8;
   localparam int RS_LSB  = 6;
   localparam int RT_MSB  = 5;
   localparam int RT_LSB  = 3;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_MOVI = 4'h1,
      OP_ADDI = 4'h2,
      OP_ADD  = 4'h3,
      OP_SUB  = 4'h4,
      OP_LD   = 4'h5,
      OP_ST   = 4'h6,
      OP_BNE  = 4'h7,
      OP_B    = 4'h8,
      OP_HALT = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_EXEC    = 2'd1,
      S_LOAD_WB = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   function automatic logic [DATA_WIDTH-1:0] sext9(input logic [8:0] v);
      return {{(DATA_WIDTH-9){v[8]}}, v};
   endfunction

endpackage

// File: rtl/cpu_core_if.sv
// Memory-controller bus between the core (master) and the word-addressed
// synchronous memory (slave).
interface cpu_core_if #(
   parameter int AW = cpu_pkg::ADDR_WIDTH
);
   logic [15:0]   MEM_MEMCTRL_from_mem_data;
   logic          MEMCTRL_MEM_to_mem_read_enable;
   logic          MEMCTRL_MEM_to_mem_write_enable;
   logic          MEMCTRL_MEM_to_mem_mem_enable;
   logic [AW-1:0] MEMCTRL_MEM_to_mem_address;
   logic [15:0]   MEMCTRL_MEM_to_mem_data;

   modport master (
      input  MEM_MEMCTRL_from_mem_data,
      output MEMCTRL_MEM_to_mem_read_enable,
      output MEMCTRL_MEM_to_mem_write_enable,
      output MEMCTRL_MEM_to_mem_mem_enable,
      output MEMCTRL_MEM_to_mem_address,
      output MEMCTRL_MEM_to_mem_data
   );

   modport slave (
      output MEM_MEMCTRL_from_mem_data,
      input  MEMCTRL_MEM_to_mem_read_enable,
      input  MEMCTRL_MEM_to_mem_write_enable,
      input  MEMCTRL_MEM_to_mem_mem_enable,
      input  MEMCTRL_MEM_to_mem_address,
      input  MEMCTRL_MEM_to_mem_data
   );
endinterface

// File: rtl/cpu_core_regfile.sv
// 8 x 16-bit register file: one synchronous write port, two combinational
// read ports.
module cpu_regfile
   import cpu_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  we,
   input  logic [2:0]            waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [2:0]            ra1,
   input  logic [2:0]            ra2,
   output logic [DATA_WIDTH-1:0] rd1,
   output logic [DATA_WIDTH-1:0] rd2
);

   logic [DATA_WIDTH-1:0] regs [8];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rd1 = regs[ra1];
   assign rd2 = regs[ra2];

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 16-bit load/store core: FETCH -> EXEC (-> LOAD_WB), with the
// memory bus decoded combinationally from registered state.
module cpu_core
   import cpu_pkg::*;
#(
   parameter int MEM_DEPTH = 4096
) (
   input  logic       clock,
   input  logic       reset,
   cpu_core_if.master mem_bus
);

   localparam int AW = $clog2(MEM_DEPTH);

   state_t                state, next_state;
   logic [DATA_WIDTH-1:0] ir;
   logic [AW-1:0]         pc;
   logic                  z;

   logic [DATA_WIDTH-1:0] mem_data;
   logic [DATA_WIDTH-1:0] instr;
   opcode_t               op;
   logic [2:0]            rd_f, rs_f, rt_f;
   logic [5:0]            imm6;
   logic [8:0]            imm9;
   logic [11:0]           imm12;

   logic [DATA_WIDTH-1:0] rd1, rd2, alu_res, rf_wdata;
   logic                  alu_we, z_we, rf_we, taken;
   logic [AW-1:0]         ea, pc_next;

   logic                  rd_en, wr_en;
   logic [AW-1:0]         addr;
   logic [DATA_WIDTH-1:0] wdata;

   assign mem_data = mem_bus.MEM_MEMCTRL_from_mem_data;

   // During EXEC the instruction is still on the read bus; afterwards it lives in IR.
   assign instr = (state == S_EXEC) ? mem_data : ir;
   assign op    = opcode_t'(instr[OP_MSB:OP_LSB]);
   assign rd_f  = instr[RD_MSB:RD_LSB];
   assign rs_f  = instr[RS_MSB:RS_LSB];
   assign rt_f  = instr[RT_MSB:RT_LSB];
   assign imm6  = instr[5:0];
   assign imm9  = instr[8:0];
   assign imm12 = instr[11:0];

   cpu_regfile u_regfile (
      .clock (clock),
      .reset (reset),
      .we    (rf_we),
      .waddr (rd_f),
      .wdata (rf_wdata),
      .ra1   ((op == OP_ADDI) ? rd_f : rs_f),
      .ra2   ((op == OP_ST)   ? rd_f : rt_f),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   always_comb begin
      alu_res = '0;
      alu_we  = 1'b0;
      z_we    = 1'b0;
      case (op)
         OP_MOVI: begin alu_res = {7'd0, imm9};     alu_we = 1'b1; end
         OP_ADDI: begin alu_res = rd1 + sext9(imm9); alu_we = 1'b1; z_we = 1'b1; end
         OP_ADD:  begin alu_res = rd1 + rd2;         alu_we = 1'b1; z_we = 1'b1; end
         OP_SUB:  begin alu_res = rd1 - rd2;         alu_we = 1'b1; z_we = 1'b1; end
         default: ;
      endcase
   end

   assign ea       = rd1[AW-1:0] + AW'(imm6);
   assign taken    = (op == OP_B) || ((op == OP_BNE) && !z);
   assign pc_next  = taken ? pc + AW'($signed(imm12)) : pc + AW'(1);
   assign rf_we    = ((state == S_EXEC) && alu_we) || (state == S_LOAD_WB);
   assign rf_wdata = (state == S_LOAD_WB) ? mem_data : alu_res;

   always_ff @(posedge clock) begin
      if (reset) begin
         pc <= '0;
         z  <= 1'b0;
         ir <= '0;
      end else if (state == S_EXEC) begin
         ir <= mem_data;
         pc <= pc_next;
         if (z_we) z <= (alu_res == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_FETCH:   next_state = S_EXEC;
         S_EXEC: begin
            if (op == OP_LD)        next_state = S_LOAD_WB;
            else if (op == OP_HALT) next_state = S_HALT;
            else                    next_state = S_FETCH;
         end
         S_LOAD_WB: next_state = S_FETCH;
         S_HALT:    next_state = S_HALT;
         default:   next_state = S_FETCH;
      endcase
   end

   // Bus is forced idle while reset is high so an aborted ST can never commit.
   always_comb begin
      rd_en = 1'b0;
      wr_en = 1'b0;
      addr  = '0;
      wdata = '0;
      if (!reset) begin
         case (state)
            S_FETCH: begin rd_en = 1'b1; addr = pc; end
            S_EXEC: begin
               if (op == OP_LD) begin
                  rd_en = 1'b1;
                  addr  = ea;
               end else if (op == OP_ST) begin
                  wr_en = 1'b1;
                  addr  = ea;
                  wdata = rd2;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_bus.MEMCTRL_MEM_to_mem_read_enable  = rd_en;
   assign mem_bus.MEMCTRL_MEM_to_mem_write_enable = wr_en;
   assign mem_bus.MEMCTRL_MEM_to_mem_mem_enable   = rd_en | wr_en;
   assign mem_bus.MEMCTRL_MEM_to_mem_address      = addr;
   assign mem_bus.MEMCTRL_MEM_to_mem_data         = wdata;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs plus random programs, each compared
// cycle by cycle against an instruction-level reference model.
module tb_cpu_core;
   import cpu_pkg::*;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic        en;
      logic [11:0] addr;
      logic [15:0] data;
   } bus_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic [15:0] mem [4096];
   logic [15:0] img [4096];
   logic [15:0] mm  [4096];
   logic [15:0] src [46];
   bus_t        exp_q[$];
   bus_t        obs_q[$];

   always #5 clock = ~clock;

   cpu_core_if bus ();

   cpu_core #(.MEM_DEPTH(4096)) dut (
      .clock   (clock),
      .reset   (reset),
      .mem_bus (bus)
   );

   // Behavioural single-port synchronous memory beside the core.
   always @(posedge clock) begin
      if (bus.MEMCTRL_MEM_to_mem_mem_enable) begin
         if (bus.MEMCTRL_MEM_to_mem_read_enable)
            bus.MEM_MEMCTRL_from_mem_data <= mem[bus.MEMCTRL_MEM_to_mem_address];
         if (bus.MEMCTRL_MEM_to_mem_write_enable)
            mem[bus.MEMCTRL_MEM_to_mem_address] = bus.MEMCTRL_MEM_to_mem_data;
      end
   end

   function automatic bus_t mk_bus(input logic r, input logic w,
                                   input logic [11:0] a, input logic [15:0] d);
      bus_t b;
      b.rd = r; b.wr = w; b.en = r | w; b.addr = a; b.data = d;
      return b;
   endfunction

   function automatic bus_t sample_bus();
      return {bus.MEMCTRL_MEM_to_mem_read_enable, bus.MEMCTRL_MEM_to_mem_write_enable,
              bus.MEMCTRL_MEM_to_mem_mem_enable, bus.MEMCTRL_MEM_to_mem_address,
              bus.MEMCTRL_MEM_to_mem_data};
   endfunction

   function automatic logic [15:0] enc_r(input opcode_t op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [2:0] rt);
      return {op, rd, rs, rt, 3'b000};
   endfunction

   function automatic logic [15:0] enc_i(input opcode_t op, input logic [2:0] rd, input logic [8:0] imm);
      return {op, rd, imm};
   endfunction

   function automatic logic [15:0] enc_m(input opcode_t op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [5:0] imm);
      return {op, rd, rs, imm};
   endfunction

   function automatic logic [15:0] enc_b(input opcode_t op, input logic [11:0] imm);
      return {op, imm};
   endfunction

   task automatic check_bus(input string tag, input bus_t exp);
      bus_t obs;
      obs = sample_bus();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got rd=%b wr=%b en=%b addr=%h data=%h, want rd=%b wr=%b en=%b addr=%h data=%h",
                tag, obs.rd, obs.wr, obs.en, obs.addr, obs.data, exp.rd, exp.wr, exp.en, exp.addr, exp.data);
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Instruction-level ISA model: runs the program in mm and lists the bus
   // activity each instruction produces, one entry per clock cycle.
   task automatic model_run(input int max_instr, output bit halted);
      logic [15:0] r [8];
      logic [11:0] pc, npc, ea;
      logic [15:0] ins, res, sum;
      logic [2:0]  rd, rs, rt;
      bit          z;
      for (int i = 0; i < 8; i++) r[i] = '0;
      pc = '0; z = 1'b0; halted = 1'b0;
      for (int n = 0; n < max_instr && !halted; n++) begin
         ins = mm[pc];
         exp_q.push_back(mk_bus(1'b1, 1'b0, pc, 16'h0));
         rd  = ins[11:9]; rs = ins[8:6]; rt = ins[5:3];
         sum = r[rs] + {10'd0, ins[5:0]};
         ea  = sum[11:0];
         npc = pc + 12'd1;
         case (ins[15:12])
            4'h1: begin r[rd] = {7'd0, ins[8:0]}; exp_q.push_back('0); end
            4'h2: begin res = r[rd] + {{7{ins[8]}}, ins[8:0]}; r[rd] = res; z = (res == 16'h0); exp_q.push_back('0); end
            4'h3: begin res = r[rs] + r[rt]; r[rd] = res; z = (res == 16'h0); exp_q.push_back('0); end
            4'h4: begin res = r[rs] - r[rt]; r[rd] = res; z = (res == 16'h0); exp_q.push_back('0); end
            4'h5: begin
               exp_q.push_back(mk_bus(1'b1, 1'b0, ea, 16'h0));
               r[rd] = mm[ea];
               exp_q.push_back('0);
            end
            4'h6: begin
               exp_q.push_back(mk_bus(1'b0, 1'b1, ea, r[rd]));
               mm[ea] = r[rd];
            end
            4'h7: begin if (!z) npc = pc + ins[11:0]; exp_q.push_back('0); end
            4'h8: begin npc = pc + ins[11:0]; exp_q.push_back('0); end
            4'hF: begin halted = 1'b1; exp_q.push_back('0); end
            default: exp_q.push_back('0);
         endcase
         pc = npc;
      end
   endtask

   task automatic clear_img();
      for (int a = 0; a < 4096; a++) img[a] = 16'h0000;
   endtask

   task automatic run_program(input string tag, input int max_instr);
      bit   halted;
      bit   bad;
      int   first_bad;
      bus_t obs;
      exp_q.delete();
      obs_q.delete();
      mm = img;
      model_run(max_instr, halted);
      @(negedge clock);
      reset = 1'b1;
      mem = img;
      repeat (3) begin
         @(negedge clock);
         check_bus({tag, " reset idle"}, '0);
      end
      reset = 1'b0;
      bad = 1'b0;
      foreach (exp_q[k]) begin
         #1;
         obs = sample_bus();
         obs_q.push_back(obs);
         if (!bad) begin
            checks++;
            assert (obs === exp_q[k]) else begin
               errors++;
               bad = 1'b1;
               $error("[TB] FAIL %s trace cycle %0d: got %h, want %h", tag, k, obs, exp_q[k]);
            end
         end
         @(negedge clock);
      end
      if (halted) begin
         repeat (3) begin
            #1;
            check_bus({tag, " halted idle"}, '0);
            @(negedge clock);
         end
      end else begin
         reset = 1'b1;
      end
      first_bad = -1;
      for (int a = 0; a < 4096; a++)
         if (mem[a] !== mm[a] && first_bad < 0) first_bad = a;
      check_val({tag, " memory image first bad addr"}, 32'(first_bad), 32'hFFFF_FFFF);
   endtask

   task automatic gen_random(input int n);
      int sel;
      for (int a = 0; a < 4096; a++) img[a] = 16'($urandom);
      for (int i = 0; i < n; i++) begin
         sel = int'($urandom_range(0, 11));
         case (sel)
            0:       img[i] = 16'h0000;
            1, 10:   img[i] = {OP_MOVI, 12'($urandom)};
            2:       img[i] = {OP_ADDI, 12'($urandom)};
            3:       img[i] = {OP_ADD,  12'($urandom)};
            4, 11:   img[i] = {OP_SUB,  12'($urandom)};
            5:       img[i] = {OP_LD,   12'($urandom)};
            6:       img[i] = {OP_ST,   12'($urandom)};
            7:       img[i] = enc_b(OP_BNE, 12'($urandom_range(1, 3)));
            8:       img[i] = enc_b(OP_B,   12'($urandom_range(1, 3)));
            default: img[i] = {4'($urandom_range(9, 14)), 12'($urandom)};
         endcase
      end
      for (int i = n; i < n + 4; i++) img[i] = 16'hF000;
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
      bus.MEM_MEMCTRL_from_mem_data = 16'h0000;

      // ALU: MOVI R1,5; ADDI R1,-5; BNE -1 (falls through); HALT
      clear_img();
      img[0] = enc_i(OP_MOVI, 3'd1, 9'd5);
      img[1] = enc_i(OP_ADDI, 3'd1, 9'h1FB);
      img[2] = enc_b(OP_BNE, 12'hFFF);
      img[3] = 16'hF000;
      run_program("alu", 20);
      check_bus_q("alu fetch0", 0, mk_bus(1'b1, 1'b0, 12'd0, 16'h0));
      check_bus_q("alu fetch1", 2, mk_bus(1'b1, 1'b0, 12'd1, 16'h0));
      check_bus_q("alu fetch2", 4, mk_bus(1'b1, 1'b0, 12'd2, 16'h0));
      check_bus_q("alu fetch3", 6, mk_bus(1'b1, 1'b0, 12'd3, 16'h0));

      // Load/store through a base register
      clear_img();
      img[0] = enc_i(OP_MOVI, 3'd2, 9'h100);
      img[1] = enc_m(OP_LD, 3'd3, 3'd2, 6'd0);
      img[2] = enc_m(OP_ST, 3'd3, 3'd2, 6'd1);
      img[3] = 16'hF000;
      img[12'h100] = 16'hBEEF;
      run_program("ldst", 20);
      check_bus_q("ldst ld strobe", 3, mk_bus(1'b1, 1'b0, 12'h100, 16'h0));
      check_bus_q("ldst st strobe", 6, mk_bus(1'b0, 1'b1, 12'h101, 16'hBEEF));
      check_val("ldst mem[0x101]", 32'(mem[12'h101]), 32'h0000_BEEF);

      // memcpy of 46 words 0x200 -> 0x300
      clear_img();
      img[0]  = enc_i(OP_MOVI, 3'd1, 9'h100);
      img[1]  = enc_r(OP_ADD, 3'd1, 3'd1, 3'd1);
      img[2]  = enc_i(OP_MOVI, 3'd2, 9'h180);
      img[3]  = enc_r(OP_ADD, 3'd2, 3'd2, 3'd2);
      img[4]  = enc_i(OP_MOVI, 3'd3, 9'd46);
      img[5]  = enc_m(OP_LD, 3'd4, 3'd1, 6'd0);
      img[6]  = enc_m(OP_ST, 3'd4, 3'd2, 6'd0);
      img[7]  = enc_i(OP_ADDI, 3'd1, 9'd1);
      img[8]  = enc_i(OP_ADDI, 3'd2, 9'd1);
      img[9]  = enc_i(OP_ADDI, 3'd3, 9'h1FF);
      img[10] = enc_b(OP_BNE, 12'hFFB);
      img[11] = 16'hF000;
      for (int i = 0; i < 46; i++) begin
         src[i] = 16'($urandom);
         img[12'h200 + 12'(i)] = src[i];
      end
      img[12'h32E] = 16'h5A5A;
      run_program("memcpy", 1000);
      for (int i = 0; i < 46; i++)
         check_val($sformatf("memcpy dst[%0d]", i), 32'(mem[12'h300 + 12'(i)]), 32'(src[i]));
      check_val("memcpy sentinel 0x32E", 32'(mem[12'h32E]), 32'h0000_5A5A);

      // PC wrap 4095 -> 0 and 16-bit add wrap 0xFFFF + 1
      clear_img();
      img[0]     = enc_b(OP_BNE, 12'hFFE);
      img[12'hFFE] = enc_r(OP_SUB, 3'd1, 3'd0, 3'd0);
      img[12'hFFF] = 16'h0000;
      img[1]     = enc_i(OP_MOVI, 3'd2, 9'd0);
      img[2]     = enc_i(OP_ADDI, 3'd2, 9'h1FF);
      img[3]     = enc_i(OP_MOVI, 3'd3, 9'd1);
      img[4]     = enc_r(OP_ADD, 3'd4, 3'd2, 3'd3);
      img[5]     = enc_m(OP_ST, 3'd4, 3'd0, 6'h20);
      img[6]     = enc_b(OP_BNE, 12'd2);
      img[7]     = 16'hF000;
      img[12'h20] = 16'hAAAA;
      run_program("wrap", 40);
      check_bus_q("wrap fetch 0xFFF", 4, mk_bus(1'b1, 1'b0, 12'hFFF, 16'h0));
      check_bus_q("wrap fetch 0 after 0xFFF", 6, mk_bus(1'b1, 1'b0, 12'h000, 16'h0));
      check_val("wrap add result", 32'(mem[12'h20]), 32'h0);

      // Reset asserted during the EXEC cycle of a ST
      clear_img();
      img[0] = enc_i(OP_MOVI, 3'd1, 9'h055);
      img[1] = enc_m(OP_ST, 3'd1, 3'd0, 6'h10);
      img[2] = 16'hF000;
      img[12'h10] = 16'h1234;
      @(negedge clock);
      reset = 1'b1;
      mem = img;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1 check_bus("midrst fetch0", mk_bus(1'b1, 1'b0, 12'd0, 16'h0));
      repeat (3) @(negedge clock);
      #1 check_bus("midrst st exec", mk_bus(1'b0, 1'b1, 12'h010, 16'h0055));
      reset = 1'b1;
      #1 check_bus("midrst gated", '0);
      @(negedge clock);
      check_val("midrst no write", 32'(mem[12'h10]), 32'h0000_1234);
      reset = 1'b0;
      #1 check_bus("midrst refetch", mk_bus(1'b1, 1'b0, 12'd0, 16'h0));
      repeat (8) @(negedge clock);
      check_val("midrst rerun write", 32'(mem[12'h10]), 32'h0000_0055);

      // Random straight-line programs with short forward branches
      for (int t = 0; t < 8; t++) begin
         gen_random(24);
         run_program($sformatf("rand%0d", t), 60);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   task automatic check_bus_q(input string tag, input int idx, input bus_t exp);
      bus_t obs;
      obs = (idx < obs_q.size()) ? obs_q[idx] : 'x;
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

endmodule
